// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_master_clkgen.sv
// Quarter-period timebase for the I2C master. Produces a tick at the end of
// every CLK_DIV-cycle quarter and the index (0..3) of the current quarter.
// With I2C_MASTER_CLK_STRETCH_EN defined, quarter 1 (SCL released) is held
// until the bus actually reads SCL high, so a slave can stretch the clock.
module i2c_master_clkgen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       scl_i,
  output logic [1:0] quarter_o,
  output logic       tick_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       quarter_q, quarter_d;
  logic             freeze;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign freeze = (quarter_q == 2'd1) && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign freeze     = 1'b0;
`endif

  // Divider: count CLK_DIV cycles per quarter, idle at zero when disabled.
  always_comb begin
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    tick_o    = 1'b0;
    if (!en_i) begin
      cnt_d     = '0;
      quarter_d = '0;
    end else if (!freeze) begin
      if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
        cnt_d     = '0;
        quarter_d = quarter_q + 2'd1;
        tick_o    = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

  assign quarter_o = quarter_q;

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, one data byte, STOP.
// Bits go out LSB-first; the R/W bit is the first address bit on the wire.
// Optional slave clock stretching: define I2C_MASTER_CLK_STRETCH_EN.
// SCL/SDA drives are decoded from registered state so an async reset
// releases both lines immediately.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                  CLK_IN,
  input  logic                  RESET_N_IN,
  input  logic                  START_IN,
  input  logic [I2C_ADDR_W-1:0] ADDR_IN,
  input  logic                  RW_IN,
  input  logic [I2C_DATA_W-1:0] WDATA_IN,
  output logic [I2C_DATA_W-1:0] RDATA_OUT,
  output logic                  BUSY_OUT,
  output logic                  DONE_OUT,
  output logic                  ACK_ERR_OUT,
  inout  wire                   SCL,
  inout  wire                   SDA
);

  i2c_state_e            state_q, state_d;
  logic [2:0]            bit_q, bit_d;
  logic [I2C_DATA_W-1:0] addr_byte_q, addr_byte_d;
  logic [I2C_DATA_W-1:0] wdata_q, wdata_d;
  logic [I2C_DATA_W-1:0] rx_q, rx_d;
  logic [I2C_DATA_W-1:0] rdata_q, rdata_d;
  logic                  nack_q, nack_d;
  logic                  ack_err_q, ack_err_d;
  logic                  done_q, done_d;

  logic       busy, tick, end_bit, smp, last_bit, data_scl;
  logic [1:0] quarter;
  logic       scl_low, sda_low, scl_in, sda_in;

  assign scl_in = SCL;
  assign sda_in = SDA;
  assign busy   = (state_q != ST_IDLE);

  i2c_master_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk_i    (CLK_IN),
    .rst_ni   (RESET_N_IN),
    .en_i     (busy),
    .scl_i    (scl_in),
    .quarter_o(quarter),
    .tick_o   (tick)
  );

  assign end_bit  = tick && (quarter == 2'd3);
  assign smp      = tick && (quarter == 2'd2);
  assign last_bit = (bit_q == 3'd7);
  assign data_scl = (quarter == 2'd0) || (quarter == 2'd3);

  // Next-state, capture and bus-drive decode.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    addr_byte_d = addr_byte_q;
    wdata_d     = wdata_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    nack_d      = nack_q;
    ack_err_d   = ack_err_q;
    done_d      = 1'b0;
    scl_low     = 1'b0;
    sda_low     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START_IN) begin
          state_d     = ST_START;
          addr_byte_d = {ADDR_IN, RW_IN};
          wdata_d     = WDATA_IN;
          ack_err_d   = 1'b0;
          bit_d       = '0;
        end
      end
      ST_START: begin
        sda_low = (quarter != 2'd0);
        scl_low = (quarter == 2'd3);
        if (end_bit) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        scl_low = data_scl;
        sda_low = !addr_byte_q[bit_q];
        if (end_bit) begin
          bit_d = bit_q + 3'd1;
          if (last_bit) state_d = ST_ADDR_ACK;
        end
      end
      ST_ADDR_ACK: begin
        scl_low = data_scl;
        if (smp) nack_d = sda_in;
        if (end_bit) begin
          if (nack_q) begin
            ack_err_d = 1'b1;
            state_d   = ST_STOP;
          end else begin
            case (addr_byte_q[0])
              I2C_RW_WRITE: state_d = ST_WRITE;
              I2C_RW_READ:  state_d = ST_READ;
            endcase
          end
        end
      end
      ST_WRITE: begin
        scl_low = data_scl;
        sda_low = !wdata_q[bit_q];
        if (end_bit) begin
          bit_d = bit_q + 3'd1;
          if (last_bit) state_d = ST_WRITE_ACK;
        end
      end
      ST_WRITE_ACK: begin
        scl_low = data_scl;
        if (smp) nack_d = sda_in;
        if (end_bit) begin
          if (nack_q) ack_err_d = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_READ: begin
        scl_low = data_scl;
        if (smp) rx_d[bit_q] = sda_in;
        if (end_bit) begin
          bit_d = bit_q + 3'd1;
          if (last_bit) state_d = ST_READ_ACK;
        end
      end
      ST_READ_ACK: begin
        scl_low = data_scl;
        if (end_bit) begin
          rdata_d = rx_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        sda_low = (quarter < 2'd2);
        scl_low = (quarter == 2'd0);
        if (end_bit) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      addr_byte_q <= '0;
      wdata_q     <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      nack_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      addr_byte_q <= addr_byte_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      nack_q      <= nack_d;
      ack_err_q   <= ack_err_d;
      done_q      <= done_d;
    end
  end

  assign SCL         = scl_low ? 1'b0 : 1'bz;
  assign SDA         = sda_low ? 1'b0 : 1'bz;
  assign RDATA_OUT   = rdata_q;
  assign BUSY_OUT    = busy;
  assign DONE_OUT    = done_q;
  assign ACK_ERR_OUT = ack_err_q;

endmodule
